// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path of the pipelined ARM core.
package cpu_pkg;

    // MOV r0,r0: presented to decode whenever no real instruction is available.
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    // Sequential fetch increment, one 32-bit ARM word.
    localparam logic [31:0] PC_STEP = 32'd4;

    // One buffered fetch result: the returned word and the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface ifetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues requests, consumes responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns words in request order.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; payload type is a parameter so the same block serves
// the instruction buffer and the issued-address queue.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output entry_t        head
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // Flush wins over everything; a push into a full FIFO is fine if the head leaves too.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Upstream credit accounting must never let a word arrive with nowhere to go.
    assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: generates fetch PCs, issues credit-limited requests to a
// variable-latency instruction memory, buffers returned words with their PCs and
// discards words that were in flight when a redirect arrived.
module ifetch_stage
    import cpu_pkg::fetch_entry_t;
    import cpu_pkg::PC_STEP;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               PCSrcW,
    input  logic [31:0]        BranchTargetW,
    ifetch_stage_if.master     imem,
    output logic [31:0]        InstrF,
    output logic [31:0]        PCPlus8,
    output logic               InstrValidF
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] drop_d;
    logic [CW:0]   credit_used;
    logic          granted;
    logic          returned;

    fetch_entry_t  buf_entry;
    fetch_entry_t  buf_head;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;

    logic [31:0]   aq_head;
    logic          aq_full;
    logic          aq_empty;
    logic [CW-1:0] aq_count;

    logic          unused_bits;
    assign unused_bits = ^{BranchTargetW[1:0], buf_full, aq_full, aq_empty, aq_count};

    // Every slot in flight or buffered consumes one credit, so the buffer can never overflow.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem.imem_req = reset && (credit_used < CREDITS);
    // A redirect may move the address under a pending request; that request is abandoned.
    assign imem.imem_addr = pc_q;

    assign granted  = imem.imem_req & imem.imem_gnt;
    assign returned = imem.imem_rvalid;

    assign buf_entry = '{instr: imem.imem_rdata, pc: aq_head};
    assign buf_pop   = InstrValidF & ~stall;

    // Issued addresses, oldest first; each response takes its PC from the head.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [31:0])
    ) u_addr_q (
        .clk       (clk),
        .reset     (reset),
        .push      (granted),
        .push_data (pc_q),
        .pop       (returned),
        .flush     (1'b0),
        .full      (aq_full),
        .empty     (aq_empty),
        .count     (aq_count),
        .head      (aq_head)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (buf_entry),
        .pop       (buf_pop),
        .flush     (PCSrcW),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (buf_head)
    );

    // Next fetch PC, in-flight count and drop count; a redirect overrides sequential flow.
    always_comb begin
        pc_d          = pc_q;
        drop_d        = drop_q;
        buf_push      = 1'b0;
        outstanding_d = outstanding_q + CW'(granted) - CW'(returned);
        if (granted) begin
            pc_d = pc_q + PC_STEP;
        end
        if (returned) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                buf_push = 1'b1;
            end
        end
        if (PCSrcW) begin
            pc_d   = {BranchTargetW[31:2], 2'b00};
            // Everything still in flight after this edge belongs to the old path.
            drop_d = outstanding_d;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Decode-facing outputs straight from the buffer head, or a NOP at the fetch PC.
    always_comb begin
        InstrValidF = ~buf_empty;
        if (buf_empty) begin
            InstrF  = NOP_INSTR;
            PCPlus8 = pc_q + 32'd8;
        end else begin
            InstrF  = buf_head.instr;
            PCPlus8 = buf_head.pc + 32'd8;
        end
    end

    // Memory must only answer requests it has actually accepted.
    assert property (@(posedge clk) disable iff (!reset)
        imem.imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        valid;
    logic        resp_en;

    logic        stall2;
    logic        pcsrc2;
    logic [31:0] target2;
    logic [31:0] instr2;
    logic [31:0] pc82;
    logic        valid2;

    int checks = 0;
    int errors = 0;

    ifetch_stage_if imem1 ();
    ifetch_stage_if imem2 ();

    ifetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .NOP_INSTR (32'hE1A0_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .PCSrcW        (pcsrc),
        .BranchTargetW (target),
        .imem          (imem1),
        .InstrF        (instr),
        .PCPlus8       (pc8),
        .InstrValidF   (valid)
    );

    // Deeper instance: the only depth where push, pop and grant can coincide.
    ifetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .NOP_INSTR (32'hE1A0_0000)
    ) dut4 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall2),
        .PCSrcW        (pcsrc2),
        .BranchTargetW (target2),
        .imem          (imem2),
        .InstrF        (instr2),
        .PCPlus8       (pc82),
        .InstrValidF   (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // Memory model 1: in-order, responses may be withheld with resp_en.
    logic [31:0] pend1 [$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend1.delete();
            imem1.imem_rvalid <= 1'b0;
            imem1.imem_rdata  <= '0;
        end else begin
            if (imem1.imem_req && imem1.imem_gnt) pend1.push_back(imem1.imem_addr);
            if (resp_en && pend1.size() != 0) begin
                imem1.imem_rvalid <= 1'b1;
                imem1.imem_rdata  <= mem_word(pend1.pop_front());
            end else begin
                imem1.imem_rvalid <= 1'b0;
            end
        end
    end

    // Memory model 2: zero-wait, always granting.
    logic [31:0] pend2 [$];
    assign imem2.imem_gnt = 1'b1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend2.delete();
            imem2.imem_rvalid <= 1'b0;
            imem2.imem_rdata  <= '0;
        end else begin
            if (imem2.imem_req) pend2.push_back(imem2.imem_addr);
            if (pend2.size() != 0) begin
                imem2.imem_rvalid <= 1'b1;
                imem2.imem_rdata  <= mem_word(pend2.pop_front());
            end else begin
                imem2.imem_rvalid <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic        stall;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc8;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic g, input logic r,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] ins, input logic [31:0] p);
        vec_t x;
        x.stall = s; x.gnt = g; x.req = r; x.addr = a;
        x.valid = v; x.instr = ins; x.pc8 = p;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Cycle 0 is the first cycle after reset release; zero-wait memory throughout.
        vecs[0]  = mk(0, 1, 1, 32'h00, 0, NOP,          32'h08);
        vecs[1]  = mk(0, 1, 1, 32'h04, 0, NOP,          32'h0C);
        vecs[2]  = mk(0, 1, 0, 32'h08, 1, 32'hE000_0000, 32'h08);
        vecs[3]  = mk(0, 1, 1, 32'h08, 1, 32'hE000_0004, 32'h0C);
        vecs[4]  = mk(0, 1, 1, 32'h0C, 0, NOP,          32'h14);
        // Stall: FIFO fills, credits exhausted, head held.
        vecs[5]  = mk(1, 1, 0, 32'h10, 1, 32'hE000_0008, 32'h10);
        vecs[6]  = mk(1, 1, 0, 32'h10, 1, 32'hE000_0008, 32'h10);
        vecs[7]  = mk(1, 1, 0, 32'h10, 1, 32'hE000_0008, 32'h10);
        vecs[8]  = mk(1, 1, 0, 32'h10, 1, 32'hE000_0008, 32'h10);
        vecs[9]  = mk(0, 1, 0, 32'h10, 1, 32'hE000_0008, 32'h10);
        // Grant withheld: address stable, buffer drains to NOP.
        vecs[10] = mk(0, 0, 1, 32'h10, 1, 32'hE000_000C, 32'h14);
        vecs[11] = mk(0, 0, 1, 32'h10, 0, NOP,          32'h18);
        vecs[12] = mk(0, 0, 1, 32'h10, 0, NOP,          32'h18);
        vecs[13] = mk(0, 0, 1, 32'h10, 0, NOP,          32'h18);
        vecs[14] = mk(0, 1, 1, 32'h10, 0, NOP,          32'h18);
        vecs[15] = mk(0, 1, 1, 32'h14, 0, NOP,          32'h1C);
        vecs[16] = mk(0, 1, 0, 32'h18, 1, 32'hE000_0010, 32'h18);
        vecs[17] = mk(0, 1, 1, 32'h18, 1, 32'hE000_0014, 32'h1C);

        reset = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = '0;
        stall2 = 1'b0; pcsrc2 = 1'b0; target2 = '0;
        imem1.imem_gnt = 1'b1; resp_en = 1'b1;

        @(negedge clk);
        #1;
        check("reset req",   32'(imem1.imem_req), 32'd0);
        check("reset addr",  imem1.imem_addr,     32'h0);
        check("reset valid", 32'(valid),          32'd0);
        check("reset instr", instr,               NOP);
        check("reset pc8",   pc8,                 32'h8);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;
            imem1.imem_gnt = vecs[i].gnt;
            #1;
            check($sformatf("v%0d req", i),   32'(imem1.imem_req), 32'(vecs[i].req));
            check($sformatf("v%0d addr", i),  imem1.imem_addr,     vecs[i].addr);
            check($sformatf("v%0d valid", i), 32'(valid),          32'(vecs[i].valid));
            check($sformatf("v%0d instr", i), instr,               vecs[i].instr);
            check($sformatf("v%0d pc8", i),   pc8,                 vecs[i].pc8);
            tick();
        end

        // Drain to idle at PC 0x1C.
        stall = 1'b0;
        imem1.imem_gnt = 1'b0;
        repeat (5) tick();
        #1;
        check("idle addr",  imem1.imem_addr, 32'h1C);
        check("idle valid", 32'(valid),      32'd0);

        // Two requests in flight, then redirect to 0x200 (low bits ignored).
        resp_en = 1'b0;
        imem1.imem_gnt = 1'b1;
        tick();
        tick();
        #1;
        check("inflight req",  32'(imem1.imem_req), 32'd0);
        check("inflight addr", imem1.imem_addr,     32'h24);
        pcsrc = 1'b1;
        target = 32'h0000_0203;
        tick();
        pcsrc = 1'b0;
        resp_en = 1'b1;
        #1;
        check("redir valid", 32'(valid),      32'd0);
        check("redir addr",  imem1.imem_addr, 32'h200);
        check("redir pc8",   pc8,             32'h208);
        for (int i = 0; i < 20; i++) begin
            if (valid) break;
            tick();
        end
        check("redir first valid", 32'(valid), 32'd1);
        check("redir first instr", instr,      32'hE000_0200);
        check("redir first pc8",   pc8,        32'h208);

        // Build up outstanding requests, then reset mid-stream.
        resp_en = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("midrst req",   32'(imem1.imem_req), 32'd0);
        check("midrst addr",  imem1.imem_addr,     32'h0);
        check("midrst valid", 32'(valid),          32'd0);
        check("midrst instr", instr,               NOP);
        check("midrst pc8",   pc8,                 32'h8);
        tick();
        tick();
        reset = 1'b1;
        resp_en = 1'b1;
        #1;
        check("restart c0 req",   32'(imem1.imem_req), 32'd1);
        check("restart c0 addr",  imem1.imem_addr,     32'h0);
        check("restart c0 valid", 32'(valid),          32'd0);
        tick();
        #1;
        check("restart c1 addr", imem1.imem_addr, 32'h4);
        tick();
        #1;
        check("restart c2 valid", 32'(valid), 32'd1);
        check("restart c2 instr", instr,      32'hE000_0000);
        check("restart c2 pc8",   pc8,        32'h8);

        // Depth-4 instance: redirect coinciding with push, pop and grant.
        check("d4 c2 valid", 32'(valid2), 32'd1);
        check("d4 c2 instr", instr2,      32'hE000_0000);
        pcsrc2 = 1'b1;
        target2 = 32'h0000_0300;
        tick();
        pcsrc2 = 1'b0;
        #1;
        check("d4 c3 valid", 32'(valid2),          32'd0);
        check("d4 c3 addr",  imem2.imem_addr,      32'h300);
        check("d4 c3 pc8",   pc82,                 32'h308);
        tick();
        #1;
        check("d4 c4 valid", 32'(valid2), 32'd0);
        tick();
        #1;
        check("d4 c5 valid", 32'(valid2), 32'd1);
        check("d4 c5 instr", instr2,      32'hE000_0300);
        check("d4 c5 pc8",   pc82,        32'h308);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
